input_conditioner: RTL

Parametrised multi-channel successor to the single-button debounce used at the board wrapper. Each of N_CH asynchronous button/switch inputs is synchronised, polarity-corrected and debounced, then decoded into a clean level plus one-cycle press, release, long-press and optional auto-repeat pulses. It sits between board pins and the core, running on the board clock, so the core's start/skip/mode logic consumes single-cycle events instead of raw levels.

---
 rtl/input_conditioner.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Multi-channel button conditioner: synchronise, debounce, and decode each pin into
// a clean level plus single-cycle press/release/long-press/auto-repeat events.
module input_conditioner #(
  parameter int              N_CH          = 3,
  parameter int              DB_CYCLES     = 500000,
  parameter int              HOLD_CYCLES   = 50000000,
  parameter int              REPEAT_CYCLES = 10000000,
  parameter logic [N_CH-1:0] ACTIVE_LOW    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_noisy,
  input  logic [N_CH-1:0] i_repeat_en,
  output logic [N_CH-1:0] o_clean,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long_press,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_any_press
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0]  REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEAT
  } state_t;

  logic [N_CH-1:0] w_press_next;
  logic            r_any_press;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      logic           r_s1;
      logic           r_s2;
      logic           r_clean;
      logic [DBW-1:0] r_db_cnt;
      logic           r_press;
      logic           r_release;
      logic           r_long;
      logic           r_rep;
      state_t         r_state;
      logic [HW-1:0]  r_hold_cnt;
      logic [RW-1:0]  r_rep_cnt;

      logic           w_clean_next;
      logic [DBW-1:0] w_db_cnt_next;
      logic           w_rise;
      logic           w_fall;
      state_t         w_state_next;
      logic [HW-1:0]  w_hold_cnt_next;
      logic [RW-1:0]  w_rep_cnt_next;
      logic           w_long_next;
      logic           w_rep_next;

      // Debounce: any sample matching the current clean level restarts the count.
      always_comb begin
        w_clean_next  = r_clean;
        w_db_cnt_next = '0;
        if (r_s2 != r_clean) begin
          if (r_db_cnt == DB_LAST) begin
            w_clean_next = r_s2;
          end else begin
            w_db_cnt_next = r_db_cnt + 1'b1;
          end
        end
      end

      assign w_rise          = !r_clean && w_clean_next;
      assign w_fall          = r_clean && !w_clean_next;
      assign w_press_next[g] = w_rise;

      // Hold FSM follows the next clean level, so a release on a terminal cycle wins.
      always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        w_rep_cnt_next  = r_rep_cnt;
        w_long_next     = 1'b0;
        w_rep_next      = 1'b0;
        if (w_fall) begin
          w_state_next    = ST_IDLE;
          w_hold_cnt_next = '0;
          w_rep_cnt_next  = '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_rise) begin
                w_state_next    = ST_HELD;
                w_hold_cnt_next = '0;
              end
            end
            ST_HELD: begin
              if (r_hold_cnt == HOLD_LAST) begin
                w_long_next    = 1'b1;
                w_state_next   = ST_REPEAT;
                w_rep_cnt_next = '0;
              end else begin
                w_hold_cnt_next = r_hold_cnt + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (r_rep_cnt == REP_LAST) begin
                w_rep_cnt_next = '0;
                w_rep_next     = i_repeat_en[g];
              end else begin
                w_rep_cnt_next = r_rep_cnt + 1'b1;
              end
            end
            default: begin
              w_state_next    = ST_IDLE;
              w_hold_cnt_next = '0;
              w_rep_cnt_next  = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1       <= 1'b0;
          r_s2       <= 1'b0;
          r_clean    <= 1'b0;
          r_db_cnt   <= '0;
          r_press    <= 1'b0;
          r_release  <= 1'b0;
          r_long     <= 1'b0;
          r_rep      <= 1'b0;
          r_state    <= ST_IDLE;
          r_hold_cnt <= '0;
          r_rep_cnt  <= '0;
        end else begin
          r_s1       <= i_noisy[g] ^ ACTIVE_LOW[g];
          r_s2       <= r_s1;
          r_clean    <= w_clean_next;
          r_db_cnt   <= w_db_cnt_next;
          r_press    <= w_rise;
          r_release  <= w_fall;
          r_long     <= w_long_next;
          r_rep      <= w_rep_next;
          r_state    <= w_state_next;
          r_hold_cnt <= w_hold_cnt_next;
          r_rep_cnt  <= w_rep_cnt_next;
        end
      end

      assign o_clean[g]      = r_clean;
      assign o_press[g]      = r_press;
      assign o_release[g]    = r_release;
      assign o_long_press[g] = r_long;
      assign o_repeat[g]     = r_rep;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_next;
    end
  end

  assign o_any_press = r_any_press;

endmodule
